// File: rtl/mem_responder.sv
// mem_responder: latency-configurable word memory answering byte/halfword/word CPU requests
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   req, we, size     - request strobe (sampled in IDLE), write enable, access size (00 B, 01 H, 10 W)
//   addr, wdata       - byte address and right-aligned write data
//   rdata             - zero-extended right-aligned read data, held until the next response
//   ack, err, busy    - one-cycle completion pulse, error flag with ack, request in flight
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic [31:0]    mem [DEPTH_WORDS];
    logic           l_we, l_err;
    logic [1:0]     l_size;
    logic [AW+1:0]  l_addr;
    logic [31:0]    l_wdata;
    logic [3:0]     cnt;
    logic           req_err;
    logic [AW-1:0]  idx;
    logic [3:0]     lanes;
    logic [31:0]    wlane, word, merged, shifted, rd_val;

    always_comb begin
        req_err = size == 2'b11 || (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00) ||
                  ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        idx     = l_addr[AW+1:2];
        word    = mem[idx];
        lanes   = l_size == 2'b00 ? 4'b0001 << l_addr[1:0] :
                  l_size == 2'b01 ? (l_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // Replicate the narrow datum across all lanes so the lane mask alone picks its position.
        wlane   = l_size == 2'b00 ? {4{l_wdata[7:0]}} :
                  l_size == 2'b01 ? {2{l_wdata[15:0]}} : l_wdata;
        merged  = word;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = lanes[i] ? wlane[8*i +: 8] : word[8*i +: 8];
        shifted = word >> {l_addr[1:0], 3'b000};
        rd_val  = l_size == 2'b00 ? {24'h0, shifted[7:0]} :
                  l_size == 2'b01 ? {16'h0, shifted[15:0]} : word;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = req ? (req_err ? RESP : WAIT) : IDLE;
            WAIT:    state_next = cnt == 4'd0 ? RESP : WAIT;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'h0;
            l_we    <= 1'b0;
            l_err   <= 1'b0;
            l_size  <= 2'b00;
            l_addr  <= '0;
            l_wdata <= 32'h0;
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                l_we    <= we;
                l_size  <= size;
                l_addr  <= addr[AW+1:0];
                l_wdata <= wdata;
                l_err   <= req_err;
                cnt     <= 4'(LATENCY - 1);
                if (req_err)
                    rdata <= 32'h0;
            end
            if (state == WAIT) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rdata <= l_we ? 32'h0 : rd_val;
                    if (l_we)
                        mem[idx] <= merged;
                end
            end
        end
    end

    assign ack  = state == RESP;
    assign err  = ack && l_err;
    assign busy = state != IDLE;
endmodule
